// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with 4-word lines and a single-outstanding refill.
// Defining ICACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module icache_dm #(
  parameter int NUM_LINES = 8,
  localparam int IDX_W = $clog2(NUM_LINES),
  localparam int TAG_W = 28 - IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_W-1:0]     tag_r [NUM_LINES];
  logic [127:0]         data_r [NUM_LINES];
  logic                 mem_read_r;
  logic [27:0]          mem_addr_r;
  logic [IDX_W-1:0]     idx_s;
  logic [IDX_W-1:0]     fill_idx_s;
  logic [TAG_W-1:0]     tag_s;
  logic [TAG_W-1:0]     fill_tag_s;
  logic [127:0]         line_s;
  logic [31:0]          word_s;
  logic                 hit_s;
  logic                 miss_s;
  logic                 fill_s;
  logic                 unused_s;

  // Writes are meaningless for an instruction cache; fold them into a sink.
  assign unused_s   = ^{proc_write, proc_wdata};

  assign idx_s      = proc_addr[IDX_W+1:2];
  assign tag_s      = proc_addr[29:IDX_W+2];
  assign fill_idx_s = mem_addr_r[IDX_W-1:0];
  assign fill_tag_s = mem_addr_r[27:IDX_W];
  assign line_s     = data_r[idx_s];
  assign hit_s      = proc_read & valid_r[idx_s] & (tag_r[idx_s] == tag_s);
  assign miss_s     = (state_r == ST_IDLE) & proc_read & ~hit_s;
  // Refill completes off the registered line address, never the live fetch address.
  assign fill_s     = (state_r == ST_REFILL) & mem_ready;

  assign mem_read   = mem_read_r;
  assign mem_addr   = mem_addr_r;
  assign mem_write  = 1'b0;
  assign mem_wdata  = 128'd0;

  // Word select within the indexed line; zero-latency hit data.
  always_comb begin
    word_s = 32'd0;
    case (proc_addr[1:0])
      2'd0:    word_s = line_s[31:0];
      2'd1:    word_s = line_s[63:32];
      2'd2:    word_s = line_s[95:64];
      2'd3:    word_s = line_s[127:96];
      default: word_s = 32'd0;
    endcase
    if (hit_s) begin
      proc_rdata = word_s;
    end else begin
      proc_rdata = 32'd0;
    end
  end

  // Stall and next-state decode.
  always_comb begin
    proc_stall  = 1'b1;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        proc_stall = miss_s;
        if (miss_s) begin
          state_nxt_s = ST_REFILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REFILL: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REFILL;
        end
      end
      ST_DONE: begin
        proc_stall  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        proc_stall  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control state, refill request and line valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mem_read_r <= 1'b0;
      mem_addr_r <= 28'd0;
      valid_r    <= {NUM_LINES{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (miss_s) begin
        mem_read_r <= 1'b1;
        mem_addr_r <= proc_addr[29:2];
      end else if (fill_s) begin
        mem_read_r          <= 1'b0;
        valid_r[fill_idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data storage; an aliasing miss simply overwrites the line.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[fill_idx_s] <= mem_rdata;
      tag_r[fill_idx_s]  <= fill_tag_s;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  // Saturating hit/miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if ((state_r == ST_IDLE) && hit_s && (hit_cnt_r != 32'hFFFF_FFFF)) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (miss_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed plus randomized fetch sequence for icache_dm, checked against
// a line-address reference model of a direct-mapped cache and a synthetic memory.
module tb_icache_dm;

  localparam int NL = 8;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  icache_dm #(.NUM_LINES(NL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which line address each slot holds, and its contents.
  bit           m_valid [NL];
  logic [27:0]  m_la    [NL];
  logic [127:0] m_data  [NL];
  int           m_hits  = 0;
  int           m_miss  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) begin
      l[32*w +: 32] = {w[1:0], 2'b10, la};
    end
    return l;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch: inputs are driven just after a rising edge, outputs sampled on the falling edge.
  task automatic fetch(input logic [29:0] a, input logic [127:0] line, input int lat);
    logic [27:0] la;
    int          li;
    int          w;
    int          n_st;
    la = a[29:2];
    li = int'(la % NL);
    w  = int'(a[1:0]);
    proc_read = 1'b1;
    proc_addr = a;
    if (m_valid[li] && (m_la[li] == la)) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hit_stall", proc_stall, 1'b0);
      chk("hit_rdata", proc_rdata, m_data[li][32*w +: 32]);
      chk("hit_mem_read", mem_read, 1'b0);
      m_hits++;
      step();
      mem_ready = 1'b0;
    end else begin
      n_st = 0;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (proc_stall === 1'b1) n_st++;
      chk("req_mem_read", mem_read, 1'b0);
      step();
      for (int k = 1; k <= lat; k++) begin
        mem_ready = (k == lat);
        mem_rdata = (k == lat) ? line : {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        if (proc_stall === 1'b1) n_st++;
        chk("refill_mem_read", mem_read, 1'b1);
        chk("refill_mem_addr", mem_addr, la);
        step();
      end
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (proc_stall === 1'b1) n_st++;
      chk("done_mem_read", mem_read, 1'b0);
      step();
      mem_ready  = 1'b0;
      m_valid[li] = 1'b1;
      m_la[li]    = la;
      m_data[li]  = line;
      m_miss++;
      @(negedge clk);
      chk("after_fill_stall", proc_stall, 1'b0);
      chk("after_fill_rdata", proc_rdata, line[32*w +: 32]);
      chk("stall_cycles", n_st, 2 + lat);
      m_hits++;
      step();
    end
`ifdef ICACHE_PERF_CNT_EN
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_miss);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 30'd0;
    proc_wdata = 32'd0;
    mem_rdata  = 128'd0;
    mem_ready  = 1'b0;
    model_clear();

    // Reset state
    @(negedge clk);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_addr", mem_addr, 28'd0);
    chk("rst_rdata", proc_rdata, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stall", proc_stall, 1'b0);
    step();

    // First miss and sequential hits within the line
    fetch(30'h4, {32'hD, 32'hC, 32'hB, 32'hA}, 2);
    fetch(30'h5, 128'd0, 1);
    fetch(30'h6, 128'd0, 1);
    fetch(30'h7, 128'd0, 1);

    // Index conflict: line 8 and line 0 share slot 0
    fetch(30'h20, mem_line(28'h8), 3);
    fetch(30'h0, mem_line(28'h0), 2);

    // Zero-wait memory, then the line hits
    fetch(30'h4C, mem_line(28'h13), 1);
    fetch(30'h4E, mem_line(28'h13), 1);

    // Reset during a refill; the late ready pulse must be ignored
    proc_read = 1'b1;
    proc_addr = 30'h44;
    @(negedge clk);
    chk("rr_req_stall", proc_stall, 1'b1);
    step();
    @(negedge clk);
    chk("rr_refill_mem_read", mem_read, 1'b1);
    step();
    rst_n     = 1'b0;
    proc_read = 1'b0;
    #1;
    chk("rr_async_mem_read", mem_read, 1'b0);
    model_clear();
    step();
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = mem_line(28'h11);
    @(negedge clk);
    chk("rr_late_mem_read", mem_read, 1'b0);
    chk("rr_late_stall", proc_stall, 1'b0);
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rr_after_mem_read", mem_read, 1'b0);
    step();
    fetch(30'h44, mem_line(28'h11), 2);
    fetch(30'h5, mem_line(28'h1), 1);

    // Write request alone does nothing
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 30'h8;
    proc_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_stall", proc_stall, 1'b0);
    chk("wr_mem_read", mem_read, 1'b0);
    step();
    @(negedge clk);
    chk("wr_mem_read_next", mem_read, 1'b0);
    step();
    proc_write = 1'b0;
    fetch(30'h8, mem_line(28'h2), 1);

    // Randomized fetches over a small address range so slots alias
    for (int i = 0; i < 60; i++) begin
      logic [27:0] la;
      logic [29:0] a;
      la = 28'($urandom_range(0, 23));
      a  = {la, 2'($urandom_range(0, 3))};
      proc_write = 1'($urandom_range(0, 1));
      fetch(a, mem_line(la), int'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) begin
        proc_read = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rnd_idle_stall", proc_stall, 1'b0);
        chk("rnd_idle_mem_read", mem_read, 1'b0);
        step();
        mem_ready = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
